sync_fifo_param: RTL and testbench



---
 rtl/sync_fifo_pkg.sv | 54 +++++
 rtl/sync_fifo_param_if.sv | 39 +++
 rtl/sync_fifo_ram.sv | 34 +++
 rtl/sync_fifo_param.sv | 173 +++++++++++++++++
 tb/tb_sync_fifo_param.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared types, flag codes and helper functions for the sync_fifo_param FIFO family.
package sync_fifo_pkg;

   typedef logic [3:0] push_flag_t;
   typedef logic [3:0] pop_flag_t;

   localparam pop_flag_t POP_EMPTY = 4'h0;
   localparam pop_flag_t POP_ONE   = 4'h1;
   localparam pop_flag_t POP_QTR   = 4'h2;
   localparam pop_flag_t POP_HALF  = 4'h3;
   localparam pop_flag_t POP_3QTR  = 4'h4;
   localparam pop_flag_t POP_NEAR  = 4'h5;
   localparam pop_flag_t POP_DM1   = 4'h6;
   localparam pop_flag_t POP_FULL  = 4'h7;

   localparam push_flag_t PUSH_FULL  = 4'h0;
   localparam push_flag_t PUSH_ONE   = 4'h1;
   localparam push_flag_t PUSH_QTR   = 4'h2;
   localparam push_flag_t PUSH_HALF  = 4'h3;
   localparam push_flag_t PUSH_MORE  = 4'h4;
   localparam push_flag_t PUSH_EMPTY = 4'hF;

   // Exact-count codes are tested first so tiny depths never alias into a range code.
   function automatic pop_flag_t level_to_pop_flag(input int unsigned level, input int unsigned depth);
      pop_flag_t f;
      if (level == 32'd0)                              f = POP_EMPTY;
      else if (level == 32'd1)                         f = POP_ONE;
      else if (level == depth)                         f = POP_FULL;
      else if (level == depth - 32'd1)                 f = POP_DM1;
      else if (level <= depth / 32'd4)                 f = POP_QTR;
      else if (level <= depth / 32'd2)                 f = POP_HALF;
      else if (level <= (32'd3 * depth) / 32'd4)       f = POP_3QTR;
      else                                             f = POP_NEAR;
      return f;
   endfunction

   function automatic push_flag_t level_to_push_flag(input int unsigned level, input int unsigned depth);
      push_flag_t  f;
      int unsigned free_words;
      free_words = depth - level;
      if (level == 32'd0)                    f = PUSH_EMPTY;
      else if (free_words == 32'd0)          f = PUSH_FULL;
      else if (free_words == 32'd1)          f = PUSH_ONE;
      else if (free_words <= depth / 32'd4)  f = PUSH_QTR;
      else if (free_words <= depth / 32'd2)  f = PUSH_HALF;
      else                                   f = PUSH_MORE;
      return f;
   endfunction

   function automatic logic parity_even(input logic [36:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Handshake/status bundle of sync_fifo_param; Parity_Err exists only with SYNC_FIFO_PARITY_EN.
interface sync_fifo_param_if
   import sync_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned DEPTH      = 512
);
   localparam int unsigned LW = $clog2(DEPTH) + 1;

   logic                  Fifo_Flush;
   logic                  PUSH;
   logic [DATA_WIDTH-1:0] DIN;
   logic                  POP;
   logic [DATA_WIDTH-1:0] DOUT;
   push_flag_t            PUSH_FLAG;
   pop_flag_t             POP_FLAG;
   logic                  Almost_Full;
   logic                  Almost_Empty;
   logic [LW-1:0]         Level;
   logic                  Overflow;
   logic                  Underflow;
`ifdef SYNC_FIFO_PARITY_EN
   logic                  Parity_Err;

   modport master (output Fifo_Flush, PUSH, DIN, POP,
                   input  DOUT, PUSH_FLAG, POP_FLAG, Almost_Full, Almost_Empty,
                          Level, Overflow, Underflow, Parity_Err);
   modport slave  (input  Fifo_Flush, PUSH, DIN, POP,
                   output DOUT, PUSH_FLAG, POP_FLAG, Almost_Full, Almost_Empty,
                          Level, Overflow, Underflow, Parity_Err);
`else
   modport master (output Fifo_Flush, PUSH, DIN, POP,
                   input  DOUT, PUSH_FLAG, POP_FLAG, Almost_Full, Almost_Empty,
                          Level, Overflow, Underflow);
   modport slave  (input  Fifo_Flush, PUSH, DIN, POP,
                   output DOUT, PUSH_FLAG, POP_FLAG, Almost_Full, Almost_Empty,
                          Level, Overflow, Underflow);
`endif
endinterface

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: one write port and one registered read port on the same clock.
module sync_fifo_ram #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 512
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     re_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [WIDTH-1:0]         rdata_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // Storage array is not reset; contents are only meaningful behind the parent's pointers.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdata_q <= {WIDTH{1'b0}};
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with registered level flags and sticky overflow/underflow.
// Define SYNC_FIFO_PARITY_EN to store a per-word even-parity bit and report read mismatches.
module sync_fifo_param
   import sync_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned DEPTH      = 512,
   parameter int unsigned AF_THRESH  = DEPTH - 4,
   parameter int unsigned AE_THRESH  = 4,
   parameter bit          REG_RD     = 1'b0
) (
   input logic              Clk,
   input logic              Rst,
   sync_fifo_param_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
`ifdef SYNC_FIFO_PARITY_EN
   localparam int unsigned SW = DATA_WIDTH + 1;
`else
   localparam int unsigned SW = DATA_WIDTH;
`endif
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
   localparam logic [LW-1:0] LVL_ONE  = {{(LW-1){1'b0}}, 1'b1};
   localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

   generate
      if (DEPTH < 4 || DEPTH > 4096 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
         $error("sync_fifo_param: DEPTH must be a power of two in 4..4096");
      end
      if (DATA_WIDTH < 1 || DATA_WIDTH > 36) begin : g_bad_width
         $error("sync_fifo_param: DATA_WIDTH must be 1..36");
      end
      if (AE_THRESH >= AF_THRESH) begin : g_bad_ae
         $error("sync_fifo_param: AE_THRESH must be below AF_THRESH");
      end
      if (AF_THRESH > DEPTH) begin : g_bad_af
         $error("sync_fifo_param: AF_THRESH must not exceed DEPTH");
      end
   endgenerate

   logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]         level_q, level_d;
   logic                  push_ok_s, pop_ok_s;
   logic                  ovf_q, ovf_d, udf_q, udf_d;
   logic                  af_q, ae_q;
   pop_flag_t             pop_flag_q;
   push_flag_t            push_flag_q;
   logic [SW-1:0]         wr_word_s, rd_word_s, mid_q, fin_word_s;
   logic                  rd_vld_q, mid_vld_q, fin_vld_s;
   logic [DATA_WIDTH-1:0] dout_q;

   // Accept decisions use the registered Level; flush overrides push/pop entirely.
   always_comb begin
      push_ok_s = 1'b0;
      pop_ok_s  = 1'b0;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      level_d   = level_q;
      ovf_d     = ovf_q;
      udf_d     = udf_q;
      if (bus.Fifo_Flush) begin
         wr_ptr_d = {AW{1'b0}};
         rd_ptr_d = {AW{1'b0}};
         level_d  = {LW{1'b0}};
      end else begin
         push_ok_s = bus.PUSH && (level_q != FULL_LVL);
         pop_ok_s  = bus.POP && (level_q != {LW{1'b0}});
         ovf_d     = ovf_q | (bus.PUSH & ~push_ok_s);
         udf_d     = udf_q | (bus.POP & ~pop_ok_s);
         wr_ptr_d  = push_ok_s ? wr_ptr_q + PTR_ONE : wr_ptr_q;
         rd_ptr_d  = pop_ok_s ? rd_ptr_q + PTR_ONE : rd_ptr_q;
         case ({push_ok_s, pop_ok_s})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         wr_ptr_q    <= {AW{1'b0}};
         rd_ptr_q    <= {AW{1'b0}};
         level_q     <= {LW{1'b0}};
         ovf_q       <= 1'b0;
         udf_q       <= 1'b0;
         af_q        <= 1'b0;
         ae_q        <= 1'b1;
         pop_flag_q  <= POP_EMPTY;
         push_flag_q <= PUSH_EMPTY;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         ovf_q       <= ovf_d;
         udf_q       <= udf_d;
         af_q        <= (32'(level_d) >= AF_THRESH);
         ae_q        <= (32'(level_d) <= AE_THRESH);
         pop_flag_q  <= level_to_pop_flag(32'(level_d), DEPTH);
         push_flag_q <= level_to_push_flag(32'(level_d), DEPTH);
      end
   end

`ifdef SYNC_FIFO_PARITY_EN
   assign wr_word_s = {parity_even(37'(bus.DIN)), bus.DIN};
`else
   assign wr_word_s = bus.DIN;
`endif

   sync_fifo_ram #(.WIDTH(SW), .DEPTH(DEPTH)) u_ram (
      .clk_i   (Clk),
      .rst_i   (Rst),
      .we_i    (push_ok_s),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_word_s),
      .re_i    (pop_ok_s),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_word_s)
   );

   always_comb begin
      if (REG_RD) begin
         fin_vld_s  = mid_vld_q;
         fin_word_s = mid_q;
      end else begin
         fin_vld_s  = rd_vld_q;
         fin_word_s = rd_word_s;
      end
   end

   // In-flight reads survive a flush; only Rst clears the read pipeline.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         rd_vld_q  <= 1'b0;
         mid_vld_q <= 1'b0;
         mid_q     <= {SW{1'b0}};
         dout_q    <= {DATA_WIDTH{1'b0}};
      end else begin
         rd_vld_q  <= pop_ok_s;
         mid_vld_q <= rd_vld_q;
         if (rd_vld_q) begin
            mid_q <= rd_word_s;
         end
         if (fin_vld_s) begin
            dout_q <= fin_word_s[DATA_WIDTH-1:0];
         end
      end
   end

`ifdef SYNC_FIFO_PARITY_EN
   logic perr_q;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         perr_q <= 1'b0;
      end else begin
         perr_q <= fin_vld_s & parity_even(37'(fin_word_s));
      end
   end

   assign bus.Parity_Err = perr_q;
`endif

   assign bus.DOUT         = dout_q;
   assign bus.Level        = level_q;
   assign bus.POP_FLAG     = pop_flag_q;
   assign bus.PUSH_FLAG    = push_flag_q;
   assign bus.Almost_Full  = af_q;
   assign bus.Almost_Empty = ae_q;
   assign bus.Overflow     = ovf_q;
   assign bus.Underflow    = udf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Drives a REG_RD=0 and a REG_RD=1 instance with identical directed + random traffic
// and compares both against a queue-based reference model.
module tb_sync_fifo_param;
   localparam int DW    = 16;
   localparam int DEPTH = 8;
   localparam int AF    = 4;
   localparam int AE    = 3;

   logic          Clk = 1'b0;
   logic          Rst;
   logic          flush, push, pop;
   logic [DW-1:0] din;

   sync_fifo_param_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) if0 ();
   sync_fifo_param_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) if1 ();

   assign if0.Fifo_Flush = flush;
   assign if0.PUSH       = push;
   assign if0.DIN        = din;
   assign if0.POP        = pop;
   assign if1.Fifo_Flush = flush;
   assign if1.PUSH       = push;
   assign if1.DIN        = din;
   assign if1.POP        = pop;

   sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .REG_RD(1'b0))
      u_dut0 (.Clk(Clk), .Rst(Rst), .bus(if0.slave));
   sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .REG_RD(1'b1))
      u_dut1 (.Clk(Clk), .Rst(Rst), .bus(if1.slave));

   always #5 Clk = ~Clk;

   typedef struct {
      int            due;
      logic [DW-1:0] v;
   } pend_t;

   logic [DW-1:0] q[$];
   pend_t         pend0[$];
   pend_t         pend1[$];
   logic [DW-1:0] dout0_m, dout1_m;
   bit            ovf_m, udf_m;
   int            cyc;
   int            n_checks;
   int            n_pass;
   int            n_fail;

   // Fill-level code straight from the code table: upper bound of each range.
   function automatic int exp_pop_flag(input int l);
      int bounds[6];
      if (l == 0) return 0;
      if (l == 1) return 1;
      if (l == DEPTH) return 7;
      if (l == DEPTH - 1) return 6;
      bounds = '{DEPTH / 4, DEPTH / 2, 3 * DEPTH / 4, DEPTH - 2, DEPTH - 1, DEPTH};
      for (int k = 0; k < 4; k++) begin
         if (l <= bounds[k]) return k + 2;
      end
      return 5;
   endfunction

   function automatic int exp_push_flag(input int l);
      int fr;
      fr = DEPTH - l;
      if (l == 0) return 15;
      if (fr == 0) return 0;
      if (fr == 1) return 1;
      if (fr <= DEPTH / 4) return 2;
      if (fr <= DEPTH / 2) return 3;
      return 4;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_all();
      int l;
      l = q.size();
      chk("lvl0",  32'(if0.Level), l);
      chk("popf0", 32'(if0.POP_FLAG), exp_pop_flag(l));
      chk("pshf0", 32'(if0.PUSH_FLAG), exp_push_flag(l));
      chk("af0",   32'(if0.Almost_Full), (l >= AF) ? 1 : 0);
      chk("ae0",   32'(if0.Almost_Empty), (l <= AE) ? 1 : 0);
      chk("ovf0",  32'(if0.Overflow), 32'(ovf_m));
      chk("udf0",  32'(if0.Underflow), 32'(udf_m));
      chk("dout0", 32'(if0.DOUT), 32'(dout0_m));
      chk("lvl1",  32'(if1.Level), l);
      chk("popf1", 32'(if1.POP_FLAG), exp_pop_flag(l));
      chk("pshf1", 32'(if1.PUSH_FLAG), exp_push_flag(l));
      chk("ovf1",  32'(if1.Overflow), 32'(ovf_m));
      chk("udf1",  32'(if1.Underflow), 32'(udf_m));
      chk("dout1", 32'(if1.DOUT), 32'(dout1_m));
`ifdef SYNC_FIFO_PARITY_EN
      chk("perr0", 32'(if0.Parity_Err), 0);
      chk("perr1", 32'(if1.Parity_Err), 0);
`endif
   endtask

   // One clock: drive inputs, advance the model with the same sampled inputs, compare.
   task automatic step(input bit r, input bit f, input bit p, input logic [DW-1:0] d, input bit o);
      bit            pa, oa;
      logic [DW-1:0] w;
      Rst = r; flush = f; push = p; din = d; pop = o;
      @(posedge Clk);
      #1;
      cyc++;
      while (pend0.size() > 0 && pend0[0].due == cyc) begin
         dout0_m = pend0[0].v;
         pend0.delete(0);
      end
      while (pend1.size() > 0 && pend1[0].due == cyc) begin
         dout1_m = pend1[0].v;
         pend1.delete(0);
      end
      if (r) begin
         q.delete(); pend0.delete(); pend1.delete();
         ovf_m = 1'b0; udf_m = 1'b0; dout0_m = '0; dout1_m = '0;
      end else if (f) begin
         q.delete();
      end else begin
         pa = p && (q.size() != DEPTH);
         oa = o && (q.size() != 0);
         if (p && !pa) ovf_m = 1'b1;
         if (o && !oa) udf_m = 1'b1;
         if (oa) begin
            w = q.pop_front();
            pend0.push_back('{cyc + 1, w});
            pend1.push_back('{cyc + 2, w});
         end
         if (pa) q.push_back(d);
      end
      check_all();
   endtask

   initial begin
      logic [DW-1:0] d;
      bit            fill_phase;
      n_checks = 0; n_pass = 0; n_fail = 0; cyc = 0;
      dout0_m = '0; dout1_m = '0; ovf_m = 1'b0; udf_m = 1'b0;
      Rst = 1'b1; flush = 1'b0; push = 1'b0; pop = 1'b0; din = '0;

      step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
      step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
      // Four words in, four out, back to back.
      for (int i = 1; i <= 4; i++) step(1'b0, 1'b0, 1'b1, 16'(i), 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
      // Fill to full, one extra push, drain.
      for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b1, 16'h1100 + 16'(i), 1'b0);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
      // Empty with push+pop, then pop the word.
      step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
      step(1'b0, 1'b0, 1'b1, 16'h3C3C, 1'b1);
      step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
      // Full with push+pop: push dropped, pop taken.
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 16'h2200 + 16'(i), 1'b0);
      step(1'b0, 1'b0, 1'b1, 16'hDEAD, 1'b1);
      for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
      // Read latency with a distinctive word, then flush with three words held.
      step(1'b0, 1'b0, 1'b1, 16'hA5A5, 1'b0);
      step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 16'h5A00 + 16'(i), 1'b0);
      step(1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b1);
      step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
      step(1'b0, 1'b0, 1'b1, 16'h7777, 1'b0);
      // Reset in the middle of a push/pop burst.
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 16'h6000 + 16'(i), i > 1);
      step(1'b1, 1'b0, 1'b1, 16'h9999, 1'b1);
      step(1'b0, 1'b0, 1'b1, 16'h4242, 1'b0);
      step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);

      // Random traffic alternating fill-biased and drain-biased phases.
      for (int i = 0; i < 600; i++) begin
         fill_phase = ((i / 40) % 2) == 0;
         d = 16'($urandom);
         step($urandom_range(0, 149) == 0, $urandom_range(0, 59) == 0,
              $urandom_range(0, 99) < (fill_phase ? 75 : 30), d,
              $urandom_range(0, 99) < (fill_phase ? 30 : 75));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
